// File: rtl/pipe_float_to_fixed_if.sv
// Valid/ready bundle between a float producer, the float-to-fixed converter
// and the fixed-point consumer.
interface pipe_float_to_fixed_if #(
  parameter int W = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_float;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          upflow;
  logic          downflow;
  logic          nan;

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out, upflow, downflow, nan
  );

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out, upflow, downflow, nan
  );
endinterface

// File: rtl/pipe_float_to_fixed.sv
// IEEE-754 single to signed WOI.WOF fixed point: unpack, scale/round, sign/saturate.
// Three registered stages that all advance together whenever the output is free.
module pipe_float_to_fixed #(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_float_to_fixed_if.slave  bus
);
  localparam int W  = WOI + WOF;
  // wide enough for a 24-bit mantissa shifted left by up to W, plus a rounding carry
  localparam int WW = W + 25;

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic en;

  logic          s1_valid_reg, s1_sign_reg, s1_nan_reg, s1_inf_reg;
  logic [7:0]    s1_exp_reg;
  logic [23:0]   s1_man_reg;

  logic          s2_valid_reg, s2_sign_reg, s2_nan_reg, s2_inf_reg, s2_ovf_reg;
  logic [W:0]    s2_mag_reg;

  logic          out_valid_reg, upflow_reg, downflow_reg, nan_reg;
  logic [W-1:0]  out_reg;

  logic [WW-1:0] m_wide, scaled;
  logic          big, rbit;
  int            sh, k;
  logic [W:0]    mag_next;
  logic          ovf_next;

  logic [W-1:0]  mag_low, wrap_val, out_next;
  logic          too_big, pos_ovf, neg_ovf;
  logic          upflow_next, downflow_next, nan_next;

  assign en           = ~out_valid_reg | bus.out_ready;
  assign bus.in_ready = en;

  // S1: unpack and classify; zero and denormals collapse to a zero mantissa
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_man_reg   <= '0;
      s1_nan_reg   <= 1'b0;
      s1_inf_reg   <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= bus.in_valid;
      s1_sign_reg  <= bus.in_float[31];
      s1_exp_reg   <= bus.in_float[30:23];
      s1_man_reg   <= (bus.in_float[30:23] != 8'd0) ? {1'b1, bus.in_float[22:0]} : 24'd0;
      s1_nan_reg   <= (bus.in_float[30:23] == 8'hFF) && (bus.in_float[22:0] != 23'd0);
      s1_inf_reg   <= (bus.in_float[30:23] == 8'hFF) && (bus.in_float[22:0] == 23'd0);
    end
  end

  // S2: magnitude = m * 2^(e-150+WOF); rounding is on the magnitude, so half away from zero
  always_comb begin
    m_wide = WW'(s1_man_reg);
    sh     = int'(s1_exp_reg) - 150 + WOF;
    k      = -sh;
    scaled = '0;
    big    = 1'b0;
    rbit   = 1'b0;
    if (sh >= 0) begin
      if (sh > W) begin
        big = |s1_man_reg;
      end else begin
        scaled = m_wide << sh;
      end
    end else if (k < 25) begin
      if (ROUND != 0) begin
        rbit = |(m_wide & (WW'(1) << (k - 1)));
      end
      scaled = (m_wide >> k) + WW'(rbit);
    end
    mag_next = scaled[W:0];
    ovf_next = big | (|scaled[WW-1:W+1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_nan_reg   <= 1'b0;
      s2_inf_reg   <= 1'b0;
      s2_ovf_reg   <= 1'b0;
      s2_mag_reg   <= '0;
    end else if (en) begin
      s2_valid_reg <= s1_valid_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_nan_reg   <= s1_nan_reg;
      s2_inf_reg   <= s1_inf_reg;
      s2_ovf_reg   <= ovf_next;
      s2_mag_reg   <= mag_next;
    end
  end

  // S3: a magnitude of exactly 2^(W-1) is still legal when negative
  always_comb begin
    mag_low       = s2_mag_reg[W-1:0];
    wrap_val      = s2_sign_reg ? -mag_low : mag_low;
    too_big       = s2_ovf_reg | s2_mag_reg[W];
    pos_ovf       = ~s2_sign_reg & (too_big | mag_low[W-1]);
    neg_ovf       = s2_sign_reg & (too_big | (mag_low[W-1] & (|mag_low[W-2:0])));
    out_next      = wrap_val;
    upflow_next   = 1'b0;
    downflow_next = 1'b0;
    nan_next      = 1'b0;
    if (s2_nan_reg) begin
      out_next = '0;
      nan_next = 1'b1;
    end else if (s2_inf_reg) begin
      if (s2_sign_reg) begin
        out_next      = MIN_VAL;
        downflow_next = 1'b1;
      end else begin
        out_next    = MAX_VAL;
        upflow_next = 1'b1;
      end
    end else if (pos_ovf) begin
      upflow_next = 1'b1;
      if (ROOF != 0) out_next = MAX_VAL;
    end else if (neg_ovf) begin
      downflow_next = 1'b1;
      if (ROOF != 0) out_next = MIN_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      upflow_reg    <= 1'b0;
      downflow_reg  <= 1'b0;
      nan_reg       <= 1'b0;
    end else if (en) begin
      out_valid_reg <= s2_valid_reg;
      out_reg       <= out_next;
      upflow_reg    <= upflow_next;
      downflow_reg  <= downflow_next;
      nan_reg       <= nan_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out       = out_reg;
  assign bus.upflow    = upflow_reg;
  assign bus.downflow  = downflow_reg;
  assign bus.nan       = nan_reg;
endmodule

// File: tb/tb_pipe_float_to_fixed.sv
// Scoreboard bench: one stimulus stream drives three converters (default, ROUND=0, ROOF=0)
// and each output is compared against a queue filled from an arithmetic model at accept time.
module tb_pipe_float_to_fixed;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_float = '0;
  logic        out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_obs = '0;

  always #5 clk = ~clk;

  pipe_float_to_fixed_if #(.W(16)) bus_a ();
  pipe_float_to_fixed_if #(.W(16)) bus_b ();
  pipe_float_to_fixed_if #(.W(16)) bus_c ();

  assign bus_a.in_valid = in_valid;  assign bus_a.in_float = in_float;  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid = in_valid;  assign bus_b.in_float = in_float;  assign bus_b.out_ready = out_ready;
  assign bus_c.in_valid = in_valid;  assign bus_c.in_float = in_float;  assign bus_c.out_ready = out_ready;

  pipe_float_to_fixed #(.WOI(8), .WOF(8), .ROOF(1), .ROUND(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pipe_float_to_fixed #(.WOI(8), .WOF(8), .ROOF(1), .ROUND(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  pipe_float_to_fixed #(.WOI(8), .WOF(8), .ROOF(0), .ROUND(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // packed result: {13'b0, out[15:0], upflow, downflow, nan}
  function automatic logic [31:0] model(input logic [31:0] f, input bit roof, input bit rnd);
    logic        s;
    logic [7:0]  e;
    logic [22:0] man;
    longint      m, mag, val;
    int          sh, k;
    bit          big;
    logic [63:0] vbits;
    logic [15:0] o;
    s = f[31]; e = f[30:23]; man = f[22:0];
    big = 1'b0; mag = 0;
    if (e == 8'hFF) begin
      if (man != 0) return {13'd0, 16'h0000, 3'b001};
      return s ? {13'd0, 16'h8000, 3'b010} : {13'd0, 16'h7FFF, 3'b100};
    end
    if (e != 0) begin
      m  = longint'({1'b1, man});
      sh = int'(e) - 142;
      if (sh >= 0) begin
        if (sh > 39) big = 1'b1;
        else mag = m << sh;
      end else begin
        k = -sh;
        if (k < 25) mag = (m >> k) + (rnd ? ((m >> (k - 1)) & 1) : 0);
      end
    end
    val   = s ? -mag : mag;
    vbits = val;
    o     = big ? 16'h0000 : vbits[15:0];
    if (!s && (big || mag > 32767)) return {13'd0, roof ? 16'h7FFF : o, 3'b100};
    if (s && (big || mag > 32768))  return {13'd0, roof ? 16'h8000 : o, 3'b010};
    return {13'd0, o, 3'b000};
  endfunction

  function automatic logic [31:0] obs_a();
    return {13'd0, bus_a.out, bus_a.upflow, bus_a.downflow, bus_a.nan};
  endfunction
  function automatic logic [31:0] obs_b();
    return {13'd0, bus_b.out, bus_b.upflow, bus_b.downflow, bus_b.nan};
  endfunction
  function automatic logic [31:0] obs_c();
    return {13'd0, bus_c.out, bus_c.upflow, bus_c.downflow, bus_c.nan};
  endfunction

  // sample between edges: pop on output transfers, push on input transfers
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_stable", obs_a(), prev_obs);
      if (bus_a.out_valid && !out_ready) check("in_ready_stall", 32'(bus_a.in_ready), 32'd0);
      prev_stall = bus_a.out_valid && !out_ready;
      prev_obs   = obs_a();
      if (bus_a.out_valid && out_ready) begin
        if (qa.size() == 0) check("a_unexpected", 32'd1, 32'd0);
        else check("a_out", obs_a(), qa.pop_front());
      end
      if (bus_b.out_valid && out_ready) begin
        if (qb.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("b_out", obs_b(), qb.pop_front());
      end
      if (bus_c.out_valid && out_ready) begin
        if (qc.size() == 0) check("c_unexpected", 32'd1, 32'd0);
        else check("c_out", obs_c(), qc.pop_front());
      end
      if (in_valid && bus_a.in_ready) begin
        qa.push_back(model(in_float, 1'b1, 1'b1));
        qb.push_back(model(in_float, 1'b1, 1'b0));
        qc.push_back(model(in_float, 1'b0, 1'b1));
        $display("accept %08h", in_float);
      end
    end
  end

  task automatic send(input logic [31:0] f);
    int n;
    in_valid = 1'b1;
    in_float = f;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.in_ready && n < 200);
    if (!bus_a.in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
  endtask

  logic [31:0] vec[] = '{32'h3FC00000, 32'hC0100000, 32'h3B000000, 32'h42FFFF00,
                         32'h43960000, 32'hC3000000, 32'hC3480000, 32'h7FC00000,
                         32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000000,
                         32'hFFC00001, 32'h007FFFFF, 32'hBB000000, 32'hC3000001};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out", obs_a(), 32'd0);
    rst = 1'b0;
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);

    // latency from the accepting cycle to the cycle where out_valid rises
    send(32'h3FC00000);
    n = 0;
    while (!bus_a.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n + 1), 32'd3);
    wait_drain();

    foreach (vec[i]) send(vec[i]);
    for (int i = 0; i < 40; i++)
      send({1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)});
    wait_drain();

    // backpressure: six items streamed while the output is held for five cycles
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000); send(32'hBF800000); send(32'h40490FDB);
        send(32'h42C80000); send(32'hC2FE0000); send(32'h3C000000);
      end
      begin
        n = 0;
        while (!bus_a.out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset with three items in flight; they must never reach the output
    out_ready = 1'b0;
    send(32'h41200000); send(32'hC1200000); send(32'h40000000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    qa.delete(); qb.delete(); qc.delete();
    rst = 1'b0;
    check("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("midrst_out", obs_a(), 32'd0);
    check("midrst_in_ready", 32'(bus_a.in_ready), 32'd1);
    out_ready = 1'b1;
    send(32'h3E800000);
    send(32'hC2000000);
    wait_drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
